clk_en_mux: RTL and testbench

Glitch-free N-way selector for clock-enable strobes in a single clock domain. Each source is a periodic enable pulse train (divider output, baud tick, etc.). The block forwards exactly one source to `en_o` and switches between sources only at period boundaries, with a programmable dead gap, so no shortened or merged enable period is ever produced. It adds what a plain two-input clock mux lacks: N sources, a valid/ready switch handshake, and timeout recovery from a dead source.

---
 rtl/clk_en_mux_pkg.sv | 15 +
 rtl/clk_en_mux.sv | 124 ++++++++++++
 tb/tb_clk_en_mux.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_mux_pkg.sv
// Shared types and helpers for the clock-enable selector.
package clk_en_mux_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT_OFF,
        GAP,
        WAIT_ON
    } clk_en_mux_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_en_mux.sv
// Glitch-free N-way clock-enable selector: switches sources only at period
// boundaries with a programmable dead gap and timeout recovery.
module clk_en_mux
    import clk_en_mux_pkg::*;
#(
    parameter  int NUM_SRC     = 4,
    parameter  int DEAD_CYCLES = 2,
    parameter  int TIMEOUT     = 1024,
    parameter  int RST_SEL     = 0,
    localparam int SW          = $clog2(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               srst_ni,
    input  logic [NUM_SRC-1:0] src_en_i,
    input  logic [SW-1:0]      sel_i,
    input  logic               sel_valid_i,
    output logic               sel_ready_o,
    output logic               en_o,
    output logic [SW-1:0]      cur_sel_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int CW = $clog2(max_int(TIMEOUT, DEAD_CYCLES) + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [SW:0]   NUM_SRC_W = (SW + 1)'(NUM_SRC);
    localparam logic [SW-1:0] RST_SEL_W = SW'(RST_SEL);
    localparam clk_en_mux_state_e AFTER_OFF = (DEAD_CYCLES == 0) ? WAIT_ON : GAP;

    clk_en_mux_state_e state_q, state_d;
    logic [SW-1:0]     cur_sel_q, cur_sel_d;
    logic [SW-1:0]     nxt_sel_q, nxt_sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              en_sel;
    logic              old_pulse;
    logic              new_pulse;
    logic              cnt_last;
    logic              sel_in_range;

    assign old_pulse    = src_en_i[cur_sel_q];
    assign new_pulse    = src_en_i[nxt_sel_q];
    assign cnt_last     = (cnt_q == TO_LAST);
    assign sel_in_range = ({1'b0, sel_i} < NUM_SRC_W);

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        nxt_sel_d = nxt_sel_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        en_sel    = 1'b0;
        case (state_q)
            RUN: begin
                en_sel = old_pulse;
                if (sel_valid_i && sel_in_range && (sel_i != cur_sel_q)) begin
                    nxt_sel_d = sel_i;
                    state_d   = WAIT_OFF;
                    cnt_d     = '0;
                end
            end
            WAIT_OFF: begin
                // Let the final old period complete before going dark.
                en_sel = old_pulse;
                if (old_pulse || cnt_last) begin
                    timeout_d = ~old_pulse;
                    state_d   = AFTER_OFF;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = WAIT_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_ON: begin
                en_sel = new_pulse;
                if (new_pulse) begin
                    cur_sel_d = nxt_sel_q;
                    state_d   = RUN;
                    cnt_d     = '0;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = WAIT_ON;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state_q   <= WAIT_ON;
            cur_sel_q <= RST_SEL_W;
            nxt_sel_q <= RST_SEL_W;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            nxt_sel_q <= nxt_sel_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign en_o        = srst_ni & en_sel;
    assign sel_ready_o = (state_q == RUN);
    assign busy_o      = (state_q != RUN);
    assign cur_sel_o   = cur_sel_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_clk_en_mux.sv
// Randomized scoreboard bench for clk_en_mux against a behavioural model of
// the switch sequence (finish old period, dead gap, wait for new pulse).
module tb_clk_en_mux;

    localparam int NUM_SRC     = 3;
    localparam int DEAD_CYCLES = 2;
    localparam int TIMEOUT     = 16;
    localparam int RST_SEL     = 1;
    localparam int SW          = $clog2(NUM_SRC);

    typedef struct packed {
        logic          en;
        logic          ready;
        logic          busy;
        logic [SW-1:0] cur;
        logic          to;
    } obs_t;

    logic               clk_i = 1'b0;
    logic               srst_ni;
    logic [NUM_SRC-1:0] src_en_i;
    logic [SW-1:0]      sel_i;
    logic               sel_valid_i;
    logic               sel_ready_o;
    logic               en_o;
    logic [SW-1:0]      cur_sel_o;
    logic               busy_o;
    logic               timeout_o;

    clk_en_mux #(
        .NUM_SRC    (NUM_SRC),
        .DEAD_CYCLES(DEAD_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .RST_SEL    (RST_SEL)
    ) dut (
        .clk_i      (clk_i),
        .srst_ni    (srst_ni),
        .src_en_i   (src_en_i),
        .sel_i      (sel_i),
        .sel_valid_i(sel_valid_i),
        .sel_ready_o(sel_ready_o),
        .en_o       (en_o),
        .cur_sel_o  (cur_sel_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   timeouts_seen = 0;

    // Source pulse-train generators.
    int src_period [NUM_SRC];
    int src_phase  [NUM_SRC];
    bit src_dead   [NUM_SRC];

    // Reference model: committed/target source plus a description of how far
    // a switch has progressed (old period done, gap cycles remaining, waiting).
    int m_committed;
    int m_target;
    bit m_busy;
    bit m_old_done;
    int m_gap_left;
    int m_waited;
    bit m_to_flag;

    task automatic modelReset();
        m_committed = RST_SEL;
        m_target    = RST_SEL;
        m_busy      = 1'b1;
        m_old_done  = 1'b1;
        m_gap_left  = 0;
        m_waited    = 0;
        m_to_flag   = 1'b0;
    endtask

    task automatic applyStimulus(input bit rst_n, input bit valid, input int sel);
        logic [NUM_SRC-1:0] src;
        obs_t e;
        @(posedge clk_i);
        #1;
        cycle++;
        for (int i = 0; i < NUM_SRC; i++) begin
            src[i] = !src_dead[i] && (src_phase[i] == 0);
            src_phase[i] = (src_phase[i] + 1) % src_period[i];
        end
        srst_ni     = rst_n;
        sel_valid_i = valid;
        sel_i       = SW'(sel);
        src_en_i    = src;

        e.ready = !m_busy;
        e.busy  = m_busy;
        e.cur   = SW'(m_committed);
        e.to    = m_to_flag;
        if (!rst_n)
            e.en = 1'b0;
        else if (!m_busy || !m_old_done)
            e.en = src[m_committed];
        else if (m_gap_left > 0)
            e.en = 1'b0;
        else
            e.en = src[m_target];
        exp_q.push_back(e);

        if (!rst_n) begin
            modelReset();
        end else if (!m_busy) begin
            m_to_flag = 1'b0;
            if (valid && sel < NUM_SRC && sel != m_committed) begin
                m_target   = sel;
                m_busy     = 1'b1;
                m_old_done = 1'b0;
                m_waited   = 0;
            end
        end else if (!m_old_done) begin
            if (src[m_committed] || m_waited == TIMEOUT - 1) begin
                m_to_flag  = !src[m_committed];
                m_old_done = 1'b1;
                m_gap_left = DEAD_CYCLES;
                m_waited   = 0;
            end else begin
                m_to_flag = 1'b0;
                m_waited++;
            end
        end else if (m_gap_left > 0) begin
            m_to_flag = 1'b0;
            m_gap_left--;
        end else begin
            if (src[m_target]) begin
                m_to_flag   = 1'b0;
                m_committed = m_target;
                m_busy      = 1'b0;
            end else if (m_waited == TIMEOUT - 1) begin
                m_to_flag = 1'b1;
                m_waited  = 0;
            end else begin
                m_to_flag = 1'b0;
                m_waited++;
            end
        end
    endtask

    task automatic checkOutput(input obs_t e);
        obs_t a;
        a = '{en: en_o, ready: sel_ready_o, busy: busy_o, cur: cur_sel_o, to: timeout_o};
        checks++;
        if (a.to === 1'b1) timeouts_seen++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL outputs cycle %0d: got en=%b rdy=%b busy=%b cur=%0d to=%b, want en=%b rdy=%b busy=%b cur=%0d to=%b",
                     cycle, a.en, a.ready, a.busy, a.cur, a.to, e.en, e.ready, e.busy, e.cur, e.to);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    task automatic rerollSources();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_period[i] = $urandom_range(1, 6);
            src_phase[i]  = $urandom_range(0, src_period[i] - 1);
            src_dead[i]   = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic idleUntilRun(input int budget);
        for (int n = 0; n < budget && m_busy; n++) applyStimulus(1, 0, 0);
        if (m_busy) begin
            failures++;
            $display("[TB] FAIL idle_budget: model still busy after %0d cycles, required idle", budget);
        end
    endtask

    initial begin
        src_period[0] = 3; src_period[1] = 4; src_period[2] = 5;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_phase[i] = i;
            src_dead[i]  = 1'b0;
        end
        modelReset();
        srst_ni     = 1'b0;
        sel_valid_i = 1'b0;
        sel_i       = '0;
        src_en_i    = '0;

        // Reset, then settle onto RST_SEL (src1, period 4).
        repeat (2) applyStimulus(0, 0, 0);
        idleUntilRun(20);
        repeat (6) applyStimulus(1, 0, 0);

        // Request the committed source, then an out-of-range index.
        applyStimulus(1, 1, RST_SEL);
        repeat (5) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 3);
        repeat (5) applyStimulus(1, 0, 0);

        // Switch src1 -> src0 (period 3), then src0 -> src2 (period 5).
        applyStimulus(1, 1, 0);
        idleUntilRun(40);
        repeat (6) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 2);
        idleUntilRun(40);
        repeat (8) applyStimulus(1, 0, 0);

        // Committed source goes dead: switch must recover via timeout.
        src_dead[2] = 1'b1;
        applyStimulus(1, 1, 1);
        idleUntilRun(60);
        src_dead[2] = 1'b0;
        repeat (6) applyStimulus(1, 0, 0);

        // Randomized traffic with periodic source re-rolls and rare resets.
        for (int n = 0; n < 2400; n++) begin
            if (n % 60 == 0) rerollSources();
            applyStimulus($urandom_range(0, 399) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3));
        end

        // Permanently dead target: repeated timeouts until reset.
        for (int i = 0; i < NUM_SRC; i++) begin
            src_period[i] = i + 2;
            src_phase[i]  = 0;
            src_dead[i]   = 1'b0;
        end
        idleUntilRun(100);
        if (m_committed == 2) begin
            applyStimulus(1, 1, 0);
            idleUntilRun(60);
        end
        src_dead[2] = 1'b1;
        applyStimulus(1, 1, 2);
        repeat (70) applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        src_dead[2] = 1'b0;
        idleUntilRun(30);
        repeat (10) applyStimulus(1, 0, 0);

        repeat (2) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        if (timeouts_seen == 0) begin
            failures++;
            $display("[TB] FAIL timeout_coverage: saw %0d timeout pulses, required >0", timeouts_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
